ctrl_stage_mc: RTL
==================

Name: ctrl_stage_mc

Overview:
Decode-and-issue control stage for the pipelined miniRV core. It decodes RV32I plus the RV32M subset, including the mul/div ops the current decoder lacks. It registers the control word into the ID/EX boundary and handles stall, flush and bubble insertion. A multicycle FSM issues M-extension ops to an external MDU with parametrised latency, holding the pipeline until the result is ready.

Parameters:
MDU_LAT, 4, MDU cycles per mul/div op; legal range 1..15.
ALU_OP_W, 5, alu_op width; widened from 4 to encode the M ops.
CNT_W, 4, latency counter width; must satisfy 2^CNT_W > MDU_LAT.

Ports:
cpu_clk  in  1  core clock, rising edge
cpu_rst  in  1  asynchronous active-high reset
id_inst  in  32  instruction in ID
id_valid  in  1  id_inst is a real instruction, not a bubble
ex_stall  in  1  downstream hold request
ex_flush  in  1  branch/jump redirect; kill the EX-bound instruction
id_stall_req  out  1  freeze PC and IF/ID
mdu_start  out  1  one-cycle MDU launch pulse
mdu_busy  out  1  FSM in BUSY
ex_valid  out  1  EX holds a real instruction
ex_wd_sel  out  2  writeback select
ex_alu_op  out  ALU_OP_W  ALU/MDU operation
ex_alub_sel  out  1  ALU B-operand select
ex_rf_we  out  1  register-file write enable
ex_dram_we  out  1  data-memory write enable
ex_sext_op  out  3  immediate format
ex_branch  out  3  {funct3[2], funct3[0], is_branch}
ex_jump  out  2  2'b10 jalr, 2'b11 jal
ex_rD1_used, ex_rD2_used  out  1 each  source-operand usage flags for hazard unit
ex_is_mdu  out  1  EX op is an M-extension op
ex_illegal  out  1  see Optional Feature

Behaviour:
- Reset (async): every output 0; FSM = IDLE; counter = 0.
- Decode (combinational), RV32I: opcodes R/I/LOAD/S/B/LUI/JAL/JALR map to the existing team encodings.
  - SUB/SRA/SRAI selected by funct7[5].
  - Shift immediates use IMM_SHIFT.
  - Branches use SUB with IMM_B.
  - S and B clear rf_we; S sets dram_we.
  - LUI and JAL clear rD1_used; only R, S and B set rD2_used.
- Decode, RV32M: OP_R with funct7 = 7'b0000001 selects MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM or REMU by funct3. These set is_mdu=1, wd_sel=ALU_C, rf_we=1.
- EX register update per rising edge, priority flush > hold > load:
  - flush: bubble. ex_valid, ex_rf_we, ex_dram_we, ex_branch[0], ex_jump, ex_is_mdu, ex_illegal all 0; other fields don't-care (implement as 0).
  - hold: when ex_stall=1 or state is BUSY, all ex_* keep their values.
  - load: decoded word captured; ex_valid=id_valid. If id_valid=0, write enables, branch[0] and jump are forced to 0.
- Latency: decode to EX outputs is 1 cycle.
- FSM IDLE → BUSY: triggered by a load cycle with id_valid=1 and is_mdu=1.
  - mdu_start=1 for exactly the next cycle.
  - Counter loads MDU_LAT-1.
- FSM BUSY: counter decrements each cycle; at 0 → DONE. With MDU_LAT=1, BUSY lasts one cycle.
- FSM DONE: result valid in EX.
  - → IDLE when ex_stall=0.
  - Otherwise stays in DONE.
  - A back-to-back MDU op loaded in the DONE→IDLE cycle enters BUSY directly.
- id_stall_req = (state==BUSY) | ex_stall. mdu_busy = (state==BUSY).
- ex_flush in BUSY or DONE: → IDLE, counter cleared, bubble inserted, id_stall_req drops the next cycle. mdu_start is never reasserted by a flushed op.
- Simultaneous ex_flush and ex_stall: flush wins.

Optional Feature:
ILLEGAL_TRAP_EN.
- Defined: an unrecognised opcode, or an OP_R funct7 not in {0000000, 0100000, 0000001}, loads ex_illegal=1 with ex_rf_we=0, ex_dram_we=0, ex_branch[0]=0, ex_jump=0 and ex_valid=id_valid.
- Undefined: ex_illegal is tied 0, and unknown instructions decode to the legacy defaults (wd_sel=ALU_C, alu_op=AND, rf_we=1, sext_op=IMM_I).

Decomposition:
- Shared include/package, extending param.v:
  - opcode constants and funct7 M-code;
  - ALU_OP_W-wide op codes, including the eight new M ops;
  - wd_sel, alub_sel and sext_op codes; ENABLE/DISABLE and READ/WRITE;
  - FSM state encodings IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
- One sub-module: ctrl_decode, purely combinational inst → control word plus is_mdu and illegal. ctrl_stage_mc instantiates it and owns the EX register and the FSM.

Test Plan:
- add x3,x1,x2 (0x002081B3), id_valid=1 → next cycle: ex_alu_op=ADD, ex_rf_we=1, ex_rD2_used=1, ex_valid=1, id_stall_req=0.
- beq x1,x2,8 (0x00208463) → ex_branch=3'b001, ex_alu_op=SUB, ex_sext_op=IMM_B, ex_rf_we=0.
- mul x5,x6,x7 (0x027302B3), MDU_LAT=4 → mdu_start high 1 cycle; id_stall_req high 4 cycles; DONE 1 cycle; EX fields stable throughout; then IDLE.
- Same mul, ex_flush on the 2nd BUSY cycle → next edge: IDLE, ex_valid=0, ex_rf_we=0, id_stall_req=0.
- ex_stall=1 with a new instruction in ID → EX outputs unchanged; ex_stall=1 plus ex_flush=1 → bubble.
- cpu_rst asserted mid-BUSY (no clock edge) → all outputs 0 immediately; FSM IDLE. With ILLEGAL_TRAP_EN, inst 0xFFFFFFFF → ex_illegal=1, ex_rf_we=0.

Source files
------------

// File: rtl/ctrl_stage_mc_pkg.sv
// rtl/ctrl_stage_mc_pkg.sv - shared encodings for the miniRV decode/issue stage
// Extends the legacy param.v codes with the M-extension ops and FSM states.
package ctrl_stage_mc_pkg;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_LOAD = 7'b0000011;
   localparam logic [6:0] OP_S    = 7'b0100011;
   localparam logic [6:0] OP_B    = 7'b1100011;
   localparam logic [6:0] OP_LUI  = 7'b0110111;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MDU  = 7'b0000001;

   localparam int ALU_CODE_W = 5;
   localparam logic [4:0] ALU_ADD    = 5'd0;
   localparam logic [4:0] ALU_SUB    = 5'd1;
   localparam logic [4:0] ALU_AND    = 5'd2;
   localparam logic [4:0] ALU_OR     = 5'd3;
   localparam logic [4:0] ALU_XOR    = 5'd4;
   localparam logic [4:0] ALU_SLL    = 5'd5;
   localparam logic [4:0] ALU_SRL    = 5'd6;
   localparam logic [4:0] ALU_SRA    = 5'd7;
   localparam logic [4:0] ALU_SLT    = 5'd8;
   localparam logic [4:0] ALU_SLTU   = 5'd9;
   localparam logic [4:0] ALU_MUL    = 5'd16;
   localparam logic [4:0] ALU_MULH   = 5'd17;
   localparam logic [4:0] ALU_MULHSU = 5'd18;
   localparam logic [4:0] ALU_MULHU  = 5'd19;
   localparam logic [4:0] ALU_DIV    = 5'd20;
   localparam logic [4:0] ALU_DIVU   = 5'd21;
   localparam logic [4:0] ALU_REM    = 5'd22;
   localparam logic [4:0] ALU_REMU   = 5'd23;

   localparam logic [1:0] WD_ALU_C = 2'd0;
   localparam logic [1:0] WD_DRAM  = 2'd1;
   localparam logic [1:0] WD_PC4   = 2'd2;
   localparam logic [1:0] WD_EXT   = 2'd3;

   localparam logic ALUB_RS2 = 1'b0;
   localparam logic ALUB_EXT = 1'b1;

   localparam logic [2:0] IMM_I     = 3'd0;
   localparam logic [2:0] IMM_SHIFT = 3'd1;
   localparam logic [2:0] IMM_S     = 3'd2;
   localparam logic [2:0] IMM_B     = 3'd3;
   localparam logic [2:0] IMM_U     = 3'd4;
   localparam logic [2:0] IMM_J     = 3'd5;

   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;
   localparam logic READ    = 1'b0;
   localparam logic WRITE   = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic [1:0] wd_sel;
      logic       alub_sel;
      logic       rf_we;
      logic       dram_we;
      logic [2:0] sext_op;
      logic [2:0] branch;
      logic [1:0] jump;
      logic       rd1_used;
      logic       rd2_used;
      logic       is_mdu;
      logic       illegal;
   } ctrl_t;

   // alt selects SUB/SRA; callers pass 0 where funct7[5] is immediate data
   function automatic logic [4:0] alu_base(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  alu_base = alt ? ALU_SUB : ALU_ADD;
         3'b001:  alu_base = ALU_SLL;
         3'b010:  alu_base = ALU_SLT;
         3'b011:  alu_base = ALU_SLTU;
         3'b100:  alu_base = ALU_XOR;
         3'b101:  alu_base = alt ? ALU_SRA : ALU_SRL;
         3'b110:  alu_base = ALU_OR;
         default: alu_base = ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/ctrl_stage_mc_decode.sv
// rtl/ctrl_stage_mc_decode.sv - combinational RV32IM decoder (ctrl_decode)
// ILLEGAL_TRAP_EN flags unknown encodings instead of using legacy defaults.
module ctrl_decode
   import ctrl_stage_mc_pkg::*;
#(
   parameter int ALU_OP_W = 5
) (
   input  logic [31:0]         inst,
   output ctrl_t               ctrl,
   output logic [ALU_OP_W-1:0] alu_op
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic [4:0] op;
   logic       unused_fields;

   assign opcode = inst[6:0];
   assign funct3 = inst[14:12];
   assign funct7 = inst[31:25];
   assign unused_fields = ^{inst[24:15], inst[11:7]};

   always_comb begin
      ctrl          = '0;
      ctrl.wd_sel   = WD_ALU_C;
      ctrl.alub_sel = ALUB_RS2;
      ctrl.rf_we    = ENABLE;
      ctrl.dram_we  = READ;
      ctrl.sext_op  = IMM_I;
      op            = ALU_AND;
      case (opcode)
         OP_R: begin
            ctrl.rd1_used = 1'b1;
            ctrl.rd2_used = 1'b1;
            if (funct7 == F7_MDU) begin
               ctrl.is_mdu = 1'b1;
               case (funct3)
                  3'b000:  op = ALU_MUL;
                  3'b001:  op = ALU_MULH;
                  3'b010:  op = ALU_MULHSU;
                  3'b011:  op = ALU_MULHU;
                  3'b100:  op = ALU_DIV;
                  3'b101:  op = ALU_DIVU;
                  3'b110:  op = ALU_REM;
                  default: op = ALU_REMU;
               endcase
            end else begin
               op = alu_base(funct3, funct7[5]);
`ifdef ILLEGAL_TRAP_EN
               if (funct7 != F7_BASE && funct7 != F7_ALT) begin
                  ctrl.illegal = 1'b1;
                  ctrl.rf_we   = DISABLE;
               end
`endif
            end
         end
         OP_I: begin
            ctrl.alub_sel = ALUB_EXT;
            ctrl.rd1_used = 1'b1;
            op            = alu_base(funct3, (funct3 == 3'b101) && funct7[5]);
            ctrl.sext_op  = (funct3[1:0] == 2'b01) ? IMM_SHIFT : IMM_I;
         end
         OP_LOAD: begin
            ctrl.wd_sel   = WD_DRAM;
            ctrl.alub_sel = ALUB_EXT;
            ctrl.rd1_used = 1'b1;
            op            = ALU_ADD;
         end
         OP_S: begin
            ctrl.alub_sel = ALUB_EXT;
            ctrl.sext_op  = IMM_S;
            ctrl.rf_we    = DISABLE;
            ctrl.dram_we  = WRITE;
            ctrl.rd1_used = 1'b1;
            ctrl.rd2_used = 1'b1;
            op            = ALU_ADD;
         end
         OP_B: begin
            ctrl.sext_op  = IMM_B;
            ctrl.rf_we    = DISABLE;
            ctrl.branch   = {funct3[2], funct3[0], 1'b1};
            ctrl.rd1_used = 1'b1;
            ctrl.rd2_used = 1'b1;
            op            = ALU_SUB;
         end
         OP_LUI: begin
            ctrl.wd_sel   = WD_EXT;
            ctrl.alub_sel = ALUB_EXT;
            ctrl.sext_op  = IMM_U;
            op            = ALU_ADD;
         end
         OP_JAL: begin
            ctrl.wd_sel  = WD_PC4;
            ctrl.sext_op = IMM_J;
            ctrl.jump    = 2'b11;
            op           = ALU_ADD;
         end
         OP_JALR: begin
            ctrl.wd_sel   = WD_PC4;
            ctrl.alub_sel = ALUB_EXT;
            ctrl.jump     = 2'b10;
            ctrl.rd1_used = 1'b1;
            op            = ALU_ADD;
         end
         default: begin
`ifdef ILLEGAL_TRAP_EN
            ctrl.illegal = 1'b1;
            ctrl.rf_we   = DISABLE;
`endif
         end
      endcase
   end

   assign alu_op = ALU_OP_W'(op);

endmodule

// File: rtl/ctrl_stage_mc.sv
// rtl/ctrl_stage_mc.sv - ID/EX control register with multicycle MDU issue FSM
// ILLEGAL_TRAP_EN (in ctrl_decode) enables the ex_illegal trap flag.
module ctrl_stage_mc
   import ctrl_stage_mc_pkg::*;
#(
   parameter int MDU_LAT  = 4,
   parameter int ALU_OP_W = 5,
   parameter int CNT_W    = 4
) (
   input  logic                cpu_clk,
   input  logic                cpu_rst,
   input  logic [31:0]         id_inst,
   input  logic                id_valid,
   input  logic                ex_stall,
   input  logic                ex_flush,
   output logic                id_stall_req,
   output logic                mdu_start,
   output logic                mdu_busy,
   output logic                ex_valid,
   output logic [1:0]          ex_wd_sel,
   output logic [ALU_OP_W-1:0] ex_alu_op,
   output logic                ex_alub_sel,
   output logic                ex_rf_we,
   output logic                ex_dram_we,
   output logic [2:0]          ex_sext_op,
   output logic [2:0]          ex_branch,
   output logic [1:0]          ex_jump,
   output logic                ex_rD1_used,
   output logic                ex_rD2_used,
   output logic                ex_is_mdu,
   output logic                ex_illegal
);

   ctrl_t               dec_ctrl;
   ctrl_t               ld_ctrl;
   ctrl_t               ex_ctrl;
   logic [ALU_OP_W-1:0] dec_alu_op;
   state_t              state, state_nx;
   logic [CNT_W-1:0]    cnt, cnt_nx;
   logic                start_nx;
   logic                do_load;

   ctrl_decode #(.ALU_OP_W(ALU_OP_W)) u_decode (
      .inst   (id_inst),
      .ctrl   (dec_ctrl),
      .alu_op (dec_alu_op)
   );

   // a bubble in ID must never write or redirect
   always_comb begin
      ld_ctrl = dec_ctrl;
      if (!id_valid) begin
         ld_ctrl.rf_we     = DISABLE;
         ld_ctrl.dram_we   = READ;
         ld_ctrl.branch[0] = 1'b0;
         ld_ctrl.jump      = 2'b00;
      end
   end

   always_comb begin
      do_load  = !ex_flush && !ex_stall && (state != BUSY);
      state_nx = state;
      cnt_nx   = cnt;
      start_nx = 1'b0;
      if (ex_flush) begin
         state_nx = IDLE;
         cnt_nx   = '0;
      end else begin
         case (state)
            BUSY: begin
               if (cnt == '0) state_nx = DONE;
               else           cnt_nx   = cnt - 1'b1;
            end
            IDLE, DONE: begin
               if (do_load) begin
                  if (id_valid && dec_ctrl.is_mdu) begin
                     state_nx = BUSY;
                     cnt_nx   = CNT_W'(MDU_LAT - 1);
                     start_nx = 1'b1;
                  end else begin
                     state_nx = IDLE;
                  end
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         state     <= IDLE;
         cnt       <= '0;
         mdu_start <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         mdu_start <= start_nx;
      end
   end

   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         ex_valid  <= 1'b0;
         ex_ctrl   <= '0;
         ex_alu_op <= '0;
      end else if (ex_flush) begin
         ex_valid  <= 1'b0;
         ex_ctrl   <= '0;
         ex_alu_op <= '0;
      end else if (do_load) begin
         ex_valid  <= id_valid;
         ex_ctrl   <= ld_ctrl;
         ex_alu_op <= dec_alu_op;
      end
   end

   assign mdu_busy     = (state == BUSY);
   assign id_stall_req = mdu_busy | ex_stall;

   assign ex_wd_sel   = ex_ctrl.wd_sel;
   assign ex_alub_sel = ex_ctrl.alub_sel;
   assign ex_rf_we    = ex_ctrl.rf_we;
   assign ex_dram_we  = ex_ctrl.dram_we;
   assign ex_sext_op  = ex_ctrl.sext_op;
   assign ex_branch   = ex_ctrl.branch;
   assign ex_jump     = ex_ctrl.jump;
   assign ex_rD1_used = ex_ctrl.rd1_used;
   assign ex_rD2_used = ex_ctrl.rd2_used;
   assign ex_is_mdu   = ex_ctrl.is_mdu;
   assign ex_illegal  = ex_ctrl.illegal;

endmodule
